// File: rtl/rand_request_arbiter.sv
// Round-robin arbiter sharing one 16-bit LFSR among N_REQ requesters.
// It reduces samples to [0, limit-1] by mask-and-reject and sequences LFSR reseeds between samples.
module rand_request_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [16*N_REQ-1:0]  i_limit,
    input  logic                 i_reseed,
    input  logic [15:0]          i_seed,
    input  logic [15:0]          i_rand_value,
    output logic                 o_rng_rst,
    output logic [15:0]          o_rng_seed,
    output logic [N_REQ-1:0]     o_ack,
    output logic [15:0]          o_value,
    output logic                 o_busy
);
    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W   = IDX_W + 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [N_REQ-1:0] ACK_ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, RESEED, SAMPLE, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   scan_idx;
    logic [SUM_W-1:0]   scan_sum;
    logic               found;
    logic [15:0]        lim;
    logic [15:0]        mask;
    logic [15:0]        seed_q;
    logic [15:0]        sel_lim;
    logic [15:0]        samp;
    logic [RETRY_W-1:0] retry;
    logic               pending;

    // Smallest 2^k-1 covering limit-1; limits 0 and 1 collapse to an all-zero mask.
    function automatic logic [15:0] mask_of(input logic [15:0] l);
        logic [15:0] x;
        x = (l <= 16'd1) ? 16'd0 : l - 16'd1;
        x = x | (x >> 1);
        x = x | (x >> 2);
        x = x | (x >> 4);
        x = x | (x >> 8);
        return x;
    endfunction

    // First requesting index at or above the rr pointer, wrapping at N_REQ.
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        scan_sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr} + SUM_W'(i);
            if (scan_sum >= SUM_W'(N_REQ)) begin
                scan_sum = scan_sum - SUM_W'(N_REQ);
            end
            if (!found && i_req[scan_sum[IDX_W-1:0]]) begin
                found    = 1'b1;
                scan_idx = scan_sum[IDX_W-1:0];
            end
        end
    end

    assign sel_lim = i_limit[16*scan_idx +: 16];
    assign samp    = i_rand_value & mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_ack      <= '0;
            o_value    <= '0;
            o_rng_rst  <= 1'b0;
            o_rng_seed <= '0;
            o_busy     <= 1'b0;
            rr         <= '0;
            grant      <= '0;
            lim        <= '0;
            mask       <= '0;
            retry      <= '0;
            pending    <= 1'b0;
            seed_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending || i_reseed) begin
                        state      <= RESEED;
                        o_rng_rst  <= 1'b1;
                        o_rng_seed <= i_reseed ? i_seed : seed_q;
                        o_busy     <= 1'b1;
                    end else if (found) begin
                        state  <= SAMPLE;
                        grant  <= scan_idx;
                        lim    <= sel_lim;
                        mask   <= mask_of(sel_lim);
                        retry  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                RESEED: begin
                    o_rng_rst <= 1'b0;
                    pending   <= 1'b0;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end
                SAMPLE: begin
                    if (lim <= 16'd1) begin
                        o_value <= '0;
                        o_ack   <= ACK_ONE << grant;
                        state   <= DONE;
                    end else if (samp < lim) begin
                        o_value <= samp;
                        o_ack   <= ACK_ONE << grant;
                        state   <= DONE;
                    end else if (retry == RETRY_W'(MAX_RETRY)) begin
                        // samp < 2*lim, so samp-lim is already in range.
                        o_value <= samp - lim;
                        o_ack   <= ACK_ONE << grant;
                        state   <= DONE;
                    end else begin
                        retry <= retry + RETRY_W'(1);
                    end
                end
                DONE: begin
                    o_ack  <= '0;
                    o_busy <= 1'b0;
                    rr     <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new reseed command wins over the clear in RESEED.
            if (i_reseed) begin
                pending <= 1'b1;
                seed_q  <= i_seed;
            end
        end
    end
endmodule

// File: tb/tb_rand_request_arbiter.sv
// Bench for rand_request_arbiter: vector table, round-robin, reseed and reset sequences.
// A queue scoreboard holds expected acks and checks them as they arrive.
module tb_rand_request_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] value;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        int          idx;
        logic [15:0] lim;
        logic [15:0] rnd;
        logic [15:0] val;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] limit = '0;
    logic        reseed = 1'b0;
    logic [15:0] seed = '0;
    logic [15:0] rand_value = '0;
    logic        rng_rst;
    logic [15:0] rng_seed;
    logic [3:0]  ack;
    logic [15:0] value;
    logic        busy;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int acks_seen = 0;
    int last_ack_cyc = 0;
    int rng_rst_count = 0;
    exp_t sb[$];

    rand_request_arbiter #(.N_REQ(N), .MAX_RETRY(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_limit      (limit),
        .i_reseed     (reseed),
        .i_seed       (seed),
        .i_rand_value (rand_value),
        .o_rng_rst    (rng_rst),
        .o_rng_seed   (rng_seed),
        .o_ack        (ack),
        .o_value      (value),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every ack pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rng_rst === 1'b1) rng_rst_count++;
        if (ack !== 4'b0000) begin
            acks_seen++;
            last_ack_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_onehot", 32'(ack), 32'(e.ack));
                check("ack_value", 32'(value), 32'(e.value));
                if (e.lat >= 0) check("ack_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [15:0] v, input int lat);
        exp_t e;
        e.ack = a; e.value = v; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
    endtask

    // Returns at the posedge closing the DONE cycle.
    task automatic wait_ack(input int prev);
        int k;
        k = 0;
        while (acks_seen == prev && k < 30) begin
            @(posedge clk);
            k++;
        end
        if (acks_seen == prev) check("ack_timeout", 32'(acks_seen), 32'(prev + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   prev;
        int   ack_c;
        int   rc0;

        vecs[0] = '{0, 16'd0,    16'hABCD, 16'd0,    2};
        vecs[1] = '{0, 16'd1,    16'hFFFF, 16'd0,    2};
        vecs[2] = '{0, 16'd5,    16'h0006, 16'd1,    5};
        vecs[3] = '{0, 16'd5,    16'h0004, 16'd4,    2};
        vecs[4] = '{1, 16'd16,   16'h1237, 16'd7,    2};
        vecs[5] = '{2, 16'h8001, 16'hFFFF, 16'h7FFE, 5};
        vecs[6] = '{3, 16'h8000, 16'hFFFF, 16'h7FFF, 2};
        vecs[7] = '{1, 16'd3,    16'h0003, 16'd0,    5};
        vecs[8] = '{2, 16'd2,    16'h0003, 16'd1,    2};
        vecs[9] = '{3, 16'd100,  16'h00C8, 16'd72,   2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_rng_rst", 32'(rng_rst), 32'd0);
        check("rst_rng_seed", 32'(rng_seed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Table of single requests
        for (int i = 0; i < 10; i++) begin
            req = '0;
            req[vecs[i].idx] = 1'b1;
            limit[16*vecs[i].idx +: 16] = vecs[i].lim;
            rand_value = vecs[i].rnd;
            prev = acks_seen;
            push(4'b0001 << vecs[i].idx, vecs[i].val, vecs[i].lat);
            wait_ack(prev);
            #1 req = '0;
        end

        // Round robin with all requesters active
        limit = {4{16'd16}};
        rand_value = 16'h00A5;
        for (int i = 0; i < 6; i++) push(4'b0001 << (i % 4), 16'd5, -1);
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            prev = acks_seen;
            wait_ack(prev);
            #1;
            if (i == 5) begin
                req = '0;
            end else begin
                req[i % 4] = 1'b0;
                @(posedge clk); #1 req[i % 4] = 1'b1;
            end
        end

        // Reseed from IDLE, two seeds
        for (int i = 0; i < 2; i++) begin
            seed = (i == 0) ? 16'h0000 : 16'hBEEF;
            reseed = 1'b1;
            @(posedge clk); #1 reseed = 1'b0;
            @(negedge clk);
            check("reseed_rng_rst", 32'(rng_rst), 32'd1);
            check("reseed_seed", 32'(rng_seed), 32'((i == 0) ? 16'h0000 : 16'hBEEF));
            check("reseed_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("reseed_rst_drop", 32'(rng_rst), 32'd0);
            check("reseed_busy_drop", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end

        // Reseed arriving during SAMPLE is deferred past the ack
        limit[15:0] = 16'd5;
        rand_value = 16'h0006;
        req = 4'b0001;
        prev = acks_seen;
        rc0 = rng_rst_count;
        push(4'b0001, 16'd1, 5);
        @(posedge clk); #1 begin reseed = 1'b1; seed = 16'h5A5A; end
        @(posedge clk); #1 reseed = 1'b0;
        wait_ack(prev);
        check("rsmp_no_early_rst", 32'(rng_rst_count), 32'(rc0));
        ack_c = last_ack_cyc;
        #1 req = '0;
        @(posedge clk);
        @(negedge clk);
        check("rsmp_rng_rst", 32'(rng_rst), 32'd1);
        check("rsmp_seed", 32'(rng_seed), 32'h5A5A);
        check("rsmp_rst_cycle", 32'(cyc), 32'(ack_c + 2));
        @(negedge clk);
        check("rsmp_rst_drop", 32'(rng_rst), 32'd0);
        @(posedge clk); #1;

        // Reseed and request in the same IDLE cycle
        limit[31:16] = 16'd16;
        rand_value = 16'h0003;
        seed = 16'h1111;
        reseed = 1'b1;
        req = 4'b0010;
        prev = acks_seen;
        push(4'b0010, 16'd3, 4);
        @(posedge clk); #1 reseed = 1'b0;
        @(negedge clk);
        check("same_rng_rst", 32'(rng_rst), 32'd1);
        check("same_seed", 32'(rng_seed), 32'h1111);
        wait_ack(prev);
        #1 req = '0;

        // Reset mid-SAMPLE aborts; rr pointer returns to 0
        limit[15:0] = 16'd5;
        limit[47:32] = 16'd5;
        rand_value = 16'h0006;
        req = 4'b0101;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 begin rst = 1'b0; rand_value = 16'h0002; end
        prev = acks_seen;
        push(4'b0001, 16'd2, 2);
        @(negedge clk);
        check("mrst_ack", 32'(ack), 32'd0);
        check("mrst_value", 32'(value), 32'd0);
        check("mrst_rng_rst", 32'(rng_rst), 32'd0);
        check("mrst_rng_seed", 32'(rng_seed), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        wait_ack(prev);
        #1 req = 4'b0100;
        prev = acks_seen;
        push(4'b0100, 16'd2, 2);
        wait_ack(prev);
        #1 req = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rand_request_arbiter.md
Name: rand_request_arbiter

Overview:
- Shares the single 16-bit LFSR random source between N_REQ game-logic requesters, such as obstacle placement, tilt noise and spawn timing.
- Each requester asks for a value in [0, limit-1]. The block grants requesters round-robin and reduces the LFSR output to the requested range by mask-and-reject sampling.
- It also sequences reseeding of the LFSR by driving the LFSR's reset and seed inputs, so that no reseed lands in the middle of a sample.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 3, maximum rejected samples before the fallback result is used.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req  in  N_REQ  per-requester request level; held high until the matching o_ack.
- i_limit  in  16*N_REQ  packed range bounds; requester k uses bits [16k+15:16k]. Must be stable while i_req[k] is high.
- i_reseed  in  1  single-cycle reseed command.
- i_seed  in  16  seed value; sampled when i_reseed=1.
- i_rand_value  in  16  current LFSR output; advances one step every clock.
- o_rng_rst  out  1  drives the LFSR reset input.
- o_rng_seed  out  16  drives the LFSR seed input.
- o_ack  out  N_REQ  one-hot, single-cycle completion pulse.
- o_value  out  16  result; valid only in the o_ack cycle, holds its last value otherwise.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (i_rst high at a clock edge): state=IDLE, o_ack=0, o_value=0, o_rng_rst=0, o_rng_seed=0, o_busy=0, rr pointer=0, retry count=0, reseed pending=0.
- Reset mid-operation aborts the operation with no ack; the requester's held request is re-arbitrated after reset.
- States: IDLE, RESEED, SAMPLE, DONE.
- Reseed capture: i_reseed=1 sets reseed pending and captures i_seed in any state.
  - A second i_reseed before the first is serviced overwrites the captured seed; only one reseed is performed.
- IDLE transitions:
  - If reseed pending: go to RESEED. Reseed takes priority over requests arriving in the same cycle.
  - Else if any i_req bit is set: grant the first set bit scanning upward from the rr pointer, wrapping at N_REQ. Latch the grant index and its limit L, clear retry count, compute mask M, then go to SAMPLE.
  - Else stay in IDLE.
- RESEED: lasts one cycle.
  - o_rng_rst=1 and o_rng_seed=captured seed; both are registered outputs.
  - Clear reseed pending; go to IDLE.
  - The LFSR presents seed^INITIAL_SEED (INITIAL_SEED=16'h1314) on the following cycle.
- Mask M: smallest 2^k-1 that is >= L-1.
  - L=0 or L=1 gives M=0.
  - L=0x8001..0xFFFF gives M=0xFFFF.
- SAMPLE: evaluated every cycle; S = i_rand_value & M.
  - If L<=1: result 0, go to DONE.
  - Else if S<L: result S, go to DONE.
  - Else if retry count = MAX_RETRY: result S-L, go to DONE. S-L is always < L because S < 2L.
  - Else: retry count +1, stay in SAMPLE. The LFSR has advanced, so the next cycle sees a new value.
- DONE: lasts one cycle.
  - o_ack[grant]=1 and o_value=result.
  - rr pointer = grant+1, wrapping to 0.
  - Go to IDLE.
- Latency: a request seen in IDLE at cycle t is acked at cycle t+2+retries. The worst case is t+2+MAX_RETRY.
- Requester protocol: the requester drops i_req on the cycle after o_ack. The block re-samples i_req only in IDLE, so back-to-back requests cost 3 cycles minimum.
- Request dropped mid-operation: the operation still completes and the ack pulses; the dropped requester ignores it. A limit that changes mid-operation is ignored because the limit was latched at grant.
- With all requesters continuously requesting, service is strictly 0,1,…,N_REQ-1,0. No requester waits more than N_REQ grants.
- o_busy=1 in RESEED, SAMPLE and DONE.

Test Plan:
- Limit 0 and limit 1: i_req=4'b0001 with limit0=0, then limit0=1 -> o_ack=4'b0001 two cycles after each request, o_value=0.
- Round robin: i_req=4'b1111 held, each requester dropping its bit for one cycle after its ack, all limits=16 -> ack order 0,1,2,3,0,1. Every o_value is < 16.
- Forced rejection: bench drives i_rand_value=16'h0006 constant, limit=5 (M=7).
  - Required: three retries, then o_ack 5 cycles after the request with o_value=1.
  - With i_rand_value=16'h0004 instead: o_value=4 at 2 cycles.
- Reseed:
  - i_reseed=1 with i_seed=16'h0000 in IDLE -> next cycle o_rng_rst=1 for exactly one cycle, o_rng_seed=16'h0000. The real LFSR then outputs 16'h1314.
  - i_reseed during SAMPLE -> o_rng_rst deferred until after the ack, and the in-flight o_value is unaffected.
- Reseed and request in the same IDLE cycle -> RESEED first, then grant. Ack 4 cycles after the request, with zero retries.
- Reset mid-SAMPLE (i_rst for 1 cycle) -> no ack. All outputs are 0 the cycle after reset, the rr pointer is 0, and the still-held request is served afterwards.
